// File: rtl/fp_operand_collector.sv
// Gathers two FP32 source operands from a 1-read-port register file and hands them to an adder.
// Latency: 4 cycles from issue to op_valid (3 when both sources are the same register); op_ready stalls in OUT.
module fp_operand_collector (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_op,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    output logic        rf_ren,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    input  logic        flush,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_in0,
    output logic [31:0] op_in1,
    output logic [4:0]  op_rd
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, OUT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  rs1_q, rs2_q, rd_q, op_rd_q, raddr_q;
    logic        sub_q, dup_q, ren_q, valid_q;
    logic [31:0] in0_q, in1_q;
    logic        src_is_r0;
    logic [31:0] data_z;
    logic [31:0] data_b;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_valid) state_d = RD_A;
            RD_A:    state_d = dup_q ? CAP_B : RD_B;
            RD_B:    state_d = CAP_B;
            CAP_B:   state_d = OUT;
            OUT:     if (op_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Data arriving in RD_B belongs to rs1, data arriving in CAP_B to rs2 (equal to rs1 when dup).
    always_comb begin
        src_is_r0 = (state_q == RD_B) ? (rs1_q == 5'd0) : (rs2_q == 5'd0);
        data_z    = src_is_r0 ? 32'h0000_0000 : rf_rdata;
        data_b    = sub_q ? {~data_z[31], data_z[30:0]} : data_z;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            sub_q   <= 1'b0;
            dup_q   <= 1'b0;
            ren_q   <= 1'b0;
            raddr_q <= '0;
            valid_q <= 1'b0;
            in0_q   <= '0;
            in1_q   <= '0;
            op_rd_q <= '0;
        end else begin
            state_q <= state_d;
            ren_q   <= (state_d == RD_A) || (state_d == RD_B);
            valid_q <= (state_d == OUT);
            case (state_d)
                RD_A:    raddr_q <= issue_rs1;
                RD_B:    raddr_q <= rs2_q;
                default: raddr_q <= '0;
            endcase
            case (state_q)
                IDLE: if (issue_valid) begin
                    rs1_q <= issue_rs1;
                    rs2_q <= issue_rs2;
                    rd_q  <= issue_rd;
                    sub_q <= (issue_op == 2'b01);
                    dup_q <= (issue_rs1 == issue_rs2);
                end
                RD_B: in0_q <= data_z;
                CAP_B: begin
                    in1_q   <= data_b;
                    op_rd_q <= rd_q;
                    if (dup_q) in0_q <= data_z;
                end
                default: ;
            endcase
        end
    end

    assign issue_ready = (state_q == IDLE);
    assign rf_ren      = ren_q;
    assign rf_raddr    = raddr_q;
    assign op_valid    = valid_q;
    assign op_in0      = in0_q;
    assign op_in1      = in1_q;
    assign op_rd       = op_rd_q;

endmodule

// File: tb/tb_fp_operand_collector.sv
// Bench for fp_operand_collector: vector table, randomized ops against a reference model, flush/reset corner cases.
module tb_fp_operand_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [1:0]  issue_op = 2'b00;
    logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
    logic        rf_ren;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata = '0;
    logic        flush = 1'b0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] op_in0, op_in1;
    logic [4:0]  op_rd;

    always #5 clk = ~clk;

    fp_operand_collector dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
        .op_in0(op_in0), .op_in1(op_in1), .op_rd(op_rd)
    );

    int tests = 0;
    int fails = 0;

    // Register file model: a read issued in one cycle returns data during the next.
    logic [31:0] rf [32];
    bit          force_ff = 1'b0;
    logic [4:0]  reads [$];
    logic        pend = 1'b0;
    logic [4:0]  pend_addr = '0;

    always @(negedge clk) begin
        pend      = rf_ren;
        pend_addr = rf_raddr;
        if (rf_ren) reads.push_back(rf_raddr);
    end

    always @(posedge clk) begin
        #1;
        rf_rdata = pend ? (force_ff ? 32'hFFFF_FFFF : rf[pend_addr]) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_val(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        return force_ff ? 32'hFFFF_FFFF : rf[r];
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input int stall,
                          input logic [31:0] exp0, input logic [31:0] exp1, input int exp_lat);
        int lat;
        lat = 99;
        @(negedge clk);
        chk({tag, " issue_ready"}, {31'b0, issue_ready}, 32'd1);
        reads.delete();
        issue_op = op; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        issue_valid = 1'b1;
        @(posedge clk);
        #1;
        issue_rs1 = 5'($urandom); issue_rs2 = 5'($urandom); issue_rd = 5'($urandom);
        issue_op = 2'($urandom);
        for (int n = 1; n <= 20; n++) begin
            issue_valid = 1'($urandom);
            op_ready    = 1'($urandom);
            @(negedge clk);
            if (op_valid) begin
                lat = n;
                break;
            end
        end
        issue_valid = 1'b0;
        op_ready    = (stall == 0);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " in0"}, op_in0, exp0);
        chk({tag, " in1"}, op_in1, exp1);
        chk({tag, " rd"}, {27'b0, op_rd}, {27'b0, rd});
        chk({tag, " nreads"}, reads.size(), (rs1 == rs2) ? 1 : 2);
        if (reads.size() >= 1) chk({tag, " read0"}, {27'b0, reads[0]}, {27'b0, rs1});
        if (reads.size() >= 2) chk({tag, " read1"}, {27'b0, reads[1]}, {27'b0, rs2});
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            chk({tag, " stall valid"}, {31'b0, op_valid}, 32'd1);
            chk({tag, " stall in0"}, op_in0, exp0);
            chk({tag, " stall in1"}, op_in1, exp1);
            chk({tag, " stall issue_ready"}, {31'b0, issue_ready}, 32'd0);
            chk({tag, " stall rf_ren"}, {31'b0, rf_ren}, 32'd0);
            if (s == stall) op_ready = 1'b1;
        end
        @(negedge clk);
        op_ready = 1'b0;
        chk({tag, " done valid"}, {31'b0, op_valid}, 32'd0);
        chk({tag, " bubble ready"}, {31'b0, issue_ready}, 32'd1);
    endtask

    // Issue a distinct-source op and abort it after 'abort_at' negedges.
    task automatic abort_op(input string tag, input bit use_rst, input int abort_at);
        @(negedge clk);
        issue_op = 2'b00; issue_rs1 = 5'd3; issue_rs2 = 5'd4; issue_rd = 5'd6;
        issue_valid = 1'b1;
        @(posedge clk);
        #1 issue_valid = 1'b0;
        for (int n = 1; n < abort_at; n++) @(negedge clk);
        @(negedge clk);
        if (use_rst) rst_n = 1'b0; else flush = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b0;
        chk({tag, " idle"}, {31'b0, issue_ready}, 32'd1);
        chk({tag, " valid"}, {31'b0, op_valid}, 32'd0);
        chk({tag, " rf_ren"}, {31'b0, rf_ren}, 32'd0);
        chk({tag, " in0 cleared"}, op_in0, 32'h0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk({tag, " no late valid"}, {31'b0, op_valid}, 32'd0);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2;
        bit          ff;
        logic [31:0] exp0, exp1;
        int          lat, stall;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{2'b00, 5'd3,  5'd4,  5'd5,  32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h3F80_0000, 32'h4000_0000, 4, 5};
        vecs[1] = '{2'b01, 5'd7,  5'd7,  5'd8,  32'h4040_0000, 32'h4040_0000, 1'b0, 32'h4040_0000, 32'hC040_0000, 3, 0};
        vecs[2] = '{2'b00, 5'd0,  5'd2,  5'd9,  32'h0,         32'h0,         1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4, 1};
        vecs[3] = '{2'b11, 5'd1,  5'd2,  5'd10, 32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h3F80_0000, 32'hBF80_0000, 4, 0};
        vecs[4] = '{2'b01, 5'd9,  5'd10, 5'd11, 32'h7FC0_0001, 32'h7F80_0000, 1'b0, 32'h7FC0_0001, 32'hFF80_0000, 4, 2};
        vecs[5] = '{2'b01, 5'd0,  5'd0,  5'd31, 32'h5555_5555, 32'h5555_5555, 1'b0, 32'h0000_0000, 32'h8000_0000, 3, 0};
        vecs[6] = '{2'b10, 5'd12, 5'd12, 5'd1,  32'hFF80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000, 32'hFF80_0000, 3, 0};
        vecs[7] = '{2'b01, 5'd13, 5'd0,  5'd2,  32'hC000_0000, 32'h1234_5678, 1'b0, 32'hC000_0000, 32'h8000_0000, 4, 0};

        for (int i = 0; i < 32; i++) rf[i] = $urandom;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset issue_ready", {31'b0, issue_ready}, 32'd1);
        chk("reset op_valid", {31'b0, op_valid}, 32'd0);
        chk("reset rf_ren", {31'b0, rf_ren}, 32'd0);
        chk("reset rf_raddr", {27'b0, rf_raddr}, 32'd0);
        chk("reset op_in0", op_in0, 32'h0);
        chk("reset op_in1", op_in1, 32'h0);
        chk("reset op_rd", {27'b0, op_rd}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            rf[vecs[i].rs1] = vecs[i].v1;
            rf[vecs[i].rs2] = vecs[i].v2;
            force_ff = vecs[i].ff;
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                   vecs[i].stall, vecs[i].exp0, vecs[i].exp1, vecs[i].lat);
        end
        force_ff = 1'b0;

        // Flush with a pending issue in IDLE: the handshake must not be taken.
        @(negedge clk);
        issue_valid = 1'b1; flush = 1'b1; issue_rs1 = 5'd5; issue_rs2 = 5'd6;
        @(negedge clk);
        issue_valid = 1'b0; flush = 1'b0;
        chk("flush-idle no take", {31'b0, issue_ready}, 32'd1);
        chk("flush-idle no read", {31'b0, rf_ren}, 32'd0);

        abort_op("flush RD_B", 1'b0, 2);
        run_op("after flush", 2'b00, 5'd3, 5'd4, 5'd5, 0, ref_val(5'd3), ref_val(5'd4), 4);
        abort_op("reset CAP_B", 1'b1, 3);
        run_op("after reset", 2'b01, 5'd20, 5'd21, 5'd22, 0, ref_val(5'd20),
               {~ref_val(5'd21)[31], ref_val(5'd21)[30:0]}, 4);

        for (int k = 0; k < 40; k++) begin
            logic [1:0]  op;
            logic [4:0]  a, b, d;
            logic [31:0] raw, e1;
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            op = 2'($urandom);
            a  = 5'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
            d  = 5'($urandom);
            raw = ref_val(b);
            e1  = (op == 2'b01) ? {~raw[31], raw[30:0]} : raw;
            run_op($sformatf("rand%0d", k), op, a, b, d, $urandom_range(0, 3),
                   ref_val(a), e1, (a == b) ? 3 : 4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_operand_collector.md
FP_OPERAND_COLLECTOR -- requirements
Module: fp_operand_collector

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL: issue_valid  input  1  an FP instruction is offered.
REQ-004 SHALL: issue_ready  output  1  collector can accept an instruction this cycle.
REQ-005 SHALL: issue_op  input  2  00 FADD, 01 FSUB, 1x treated as FADD.
REQ-006 SHALL: issue_rs1, issue_rs2, issue_rd  input  5 each  source and destination register indices.
REQ-007 SHALL: rf_ren  output  1  register-file read enable.
REQ-008 SHALL: rf_raddr  output  5  register-file read address.
REQ-009 SHALL: rf_rdata  input  32  read data, valid exactly one cycle after rf_ren=1.
REQ-010 SHALL: flush  input  1  synchronous abort of the in-flight instruction.
REQ-011 SHALL: op_valid  output  1  operand pair presented to the downstream FP32 adder.
REQ-012 SHALL: op_ready  input  1  downstream accepts the pair.
REQ-013 SHALL: op_in0, op_in1  output  32 each  IEEE-754 single operands.
REQ-014 SHALL: op_rd  output  5  destination tag travelling with the operands.

Function
REQ-015 SHALL: FSM states IDLE, RD_A, RD_B, CAP_B, OUT.
REQ-016 SHALL: issue_ready = 1 only in IDLE; handshake occurs when issue_valid & issue_ready at a rising edge; rs1, rs2, rd, op and dup = (rs1==rs2) are registered, and the FSM moves to RD_A.
REQ-017 SHALL: RD_A drives rf_ren=1 and rf_raddr=rs1; next state is CAP_B if dup, else RD_B.
REQ-018 SHALL: RD_B drives rf_ren=1 and rf_raddr=rs2, and captures op_in0 from the rs1 data; next state is CAP_B.
REQ-019 SHALL: CAP_B drives rf_ren=0; it captures op_in1 from the returned data; if dup, op_in0 is captured from the same data; next state is OUT.
REQ-020 SHALL: register index 0 reads as 32'h0000_0000 regardless of rf_rdata; the read is still issued.
REQ-021 SHALL: for FSUB, op_in1 = {~data[31], data[30:0]}; op_in0 is never modified; NaN/Inf payloads pass unchanged except for the FSUB sign flip.
REQ-022 SHALL: in OUT, op_valid = 1 and op_in0/op_in1/op_rd are held stable until op_valid & op_ready at a rising edge, then the FSM moves to IDLE.
REQ-023 SHALL: latency from the issue handshake edge to op_valid = 1 is 4 cycles for distinct sources and 3 cycles for dup.
REQ-024 SHALL: after each op handshake there is exactly one IDLE bubble cycle; there is no overlap of instructions.
REQ-025 SHALL: rf_ren = 0 and rf_raddr = 0 in IDLE and OUT.
REQ-026 SHALL: flush = 1 at a rising edge forces IDLE from any state, drops op_valid next cycle, and discards captured data.
REQ-027 SHALL: flush has priority over an op or issue handshake in the same cycle; the handshake is not counted as taken.
REQ-028 SHALL: op_ready is ignored outside OUT; issue_valid is ignored outside IDLE.

Reset
REQ-029 SHALL: when rst_n = 0 at a rising edge: state = IDLE; op_valid = 0; op_in0 = op_in1 = 32'h0; op_rd = 0; rf_ren = 0; rf_raddr = 0; internal registers are cleared.
REQ-030 SHALL: issue_ready = 1 in the first cycle after reset is released.
REQ-031 SHALL: reset asserted mid-operation, in any state, aborts identically to REQ-029, and the aborted instruction never produces op_valid.

Verification
REQ-032 SHALL: FADD rs1=3 (3F800000), rs2=4 (40000000), rd=5 -> reads r3 then r4; op_valid at T+4 with in0=3F800000, in1=40000000, rd=5.
REQ-033 SHALL: FSUB rs1=rs2=7 (40400000) -> exactly one read; op_valid at T+3 with in0=40400000, in1=C0400000.
REQ-034 SHALL: FADD rs1=0, rs2=2 while rf_rdata=FFFFFFFF on every read -> in0=00000000, in1=FFFFFFFF.
REQ-035 SHALL: op_ready held 0 for 5 cycles in OUT -> op_valid and data stable throughout; issue_ready=0; with op_ready=1, IDLE follows and issue_ready=1.
REQ-036 SHALL: flush in RD_B, and separately rst_n=0 in CAP_B -> IDLE next cycle; no op_valid; a new issue then completes normally.
REQ-037 SHALL: issue_op=2'b11 with r1=3F800000, r2=BF800000 -> behaves as FADD, with in1=BF800000 not sign-flipped.
